// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, RAM handshake states and memory arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arb_state_t;

    localparam word_t ERR_LOAD = 32'h0;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data memory; data wins ties.
// Optional fetch anti-starvation streak counter is compiled in with ARB_FAIRNESS_EN.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    arb_state_t state_q;
    logic       ren_q;
    logic       wen_q;
    word_t      addr_q;
    word_t      store_q;
    logic       memerr_q;

    logic dreq;
    logic done;
    logic fair_pick_i;
    logic grant_d;
    logic grant_i;

    assign dreq = dREN | dWEN;
    assign done = (ramstate == ACCESS) || (ramstate == ERROR);

    assign grant_d = (state_q == IDLE) && dreq && !fair_pick_i;
    assign grant_i = (state_q == IDLE) && !grant_d && iREN;

`ifdef ARB_FAIRNESS_EN
    localparam logic [2:0] STREAK_LIM = 3'((MAX_DSTREAK > 7) ? 7 : MAX_DSTREAK);

    logic [2:0] streak_q;

    assign fair_pick_i = iREN && (streak_q >= STREAK_LIM);

    always_ff @(posedge CLK) begin
        if (RST || !iREN) begin
            streak_q <= '0;
        end else if (grant_i) begin
            streak_q <= '0;
        end else if (grant_d && (streak_q != 3'd7)) begin
            streak_q <= streak_q + 3'd1;
        end
    end
`else
    logic [31:0] unused_max_dstreak;

    assign fair_pick_i        = 1'b0;
    assign unused_max_dstreak = 32'(MAX_DSTREAK);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q <= DGNT;
                        ren_q   <= dREN;
                        wen_q   <= dWEN;
                        addr_q  <= daddr;
                        store_q <= dstore;
                    end else if (grant_i) begin
                        state_q <= IGNT;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                        addr_q  <= iaddr;
                        store_q <= '0;
                    end
                end
                IGNT, DGNT: begin
                    // A dropped data request still completes; only a fetch can be flushed.
                    if (done || ((state_q == IGNT) && !iREN)) begin
                        state_q <= IDLE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        addr_q  <= '0;
                        store_q <= '0;
                        if (ramstate == ERROR) begin
                            memerr_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b0;
                    addr_q  <= '0;
                    store_q <= '0;
                end
            endcase
        end
    end

    assign iwait = iREN && !((state_q == IGNT) && done);
    assign dwait = dreq && !((state_q == DGNT) && done);

    assign iload = ((state_q == IGNT) && (ramstate == ACCESS)) ? ramload : ERR_LOAD;
    assign dload = ((state_q == DGNT) && (ramstate == ACCESS)) ? ramload : ERR_LOAD;

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign memerr   = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter plus fairness/starvation sequence.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    int checks = 0;
    int errors = 0;

    memory_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data requests must be held until dwait falls.
    logic dreq_p = 1'b0;
    logic dwait_p = 1'b0;
    logic rst_p = 1'b1;
    always @(posedge CLK) begin
        assert (!(!rst_p && !RST && dreq_p && dwait_p && !(dREN | dWEN)))
            else $error("FAIL protocol data request dropped while dwait high");
        dreq_p  <= dREN | dWEN;
        dwait_p <= dwait;
        rst_p   <= RST;
    end

    typedef struct {
        logic      rst, iren, dren, dwen;
        word_t     ia, da, ds, rl;
        ramstate_t rs;
        logic      e_iwait, e_dwait, e_ren, e_wen, e_err;
        word_t     e_iload, e_dload, e_addr, e_store;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(
        input logic rst, input logic iren, input word_t ia,
        input logic dren, input logic dwen, input word_t da, input word_t ds,
        input ramstate_t rs, input word_t rl,
        input logic e_iwait, input logic e_dwait, input word_t e_iload, input word_t e_dload,
        input logic e_ren, input logic e_wen, input word_t e_addr, input word_t e_store,
        input logic e_err);
        vec_t v;
        v.rst = rst; v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen;
        v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iwait = e_iwait; v.e_dwait = e_dwait; v.e_iload = e_iload; v.e_dload = e_dload;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // rst iren iaddr  dren dwen daddr  dstore  rs  ramload | iwait dwait iload dload ren wen addr store err
        tbl[0]  = mk(1,1,32'h40, 0,0,32'h0,  32'h0,        FREE,  32'h0,        1,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[1]  = mk(0,1,32'h40, 0,0,32'h0,  32'h0,        FREE,  32'h0,        1,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[2]  = mk(0,1,32'h40, 0,0,32'h0,  32'h0,        BUSY,  32'h0,        1,0,32'h0,32'h0,        1,0,32'h40, 32'h0,        0);
        tbl[3]  = mk(0,1,32'h40, 0,0,32'h0,  32'h0,        BUSY,  32'h0,        1,0,32'h0,32'h0,        1,0,32'h40, 32'h0,        0);
        tbl[4]  = mk(0,1,32'h40, 0,0,32'h0,  32'h0,        ACCESS,32'h3C010001, 0,0,32'h3C010001,32'h0, 1,0,32'h40, 32'h0,        0);
        tbl[5]  = mk(0,0,32'h40, 0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[6]  = mk(0,1,32'h44, 0,1,32'h100,32'hDEADBEEF, FREE,  32'h0,        1,1,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[7]  = mk(0,1,32'h44, 0,1,32'h100,32'hDEADBEEF, BUSY,  32'h0,        1,1,32'h0,32'h0,        0,1,32'h100,32'hDEADBEEF, 0);
        tbl[8]  = mk(0,1,32'h44, 0,1,32'h100,32'hDEADBEEF, ACCESS,32'h0,        1,0,32'h0,32'h0,        0,1,32'h100,32'hDEADBEEF, 0);
        tbl[9]  = mk(0,1,32'h44, 0,0,32'h100,32'hDEADBEEF, FREE,  32'h0,        1,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[10] = mk(0,1,32'h44, 0,0,32'h0,  32'h0,        ACCESS,32'hA5A5A5A5, 0,0,32'hA5A5A5A5,32'h0, 1,0,32'h44, 32'h0,        0);
        tbl[11] = mk(0,0,32'h44, 0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[12] = mk(0,1,32'h48, 0,0,32'h0,  32'h0,        FREE,  32'h0,        1,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[13] = mk(0,1,32'h48, 0,0,32'h0,  32'h0,        BUSY,  32'h0,        1,0,32'h0,32'h0,        1,0,32'h48, 32'h0,        0);
        tbl[14] = mk(0,0,32'h48, 0,0,32'h0,  32'h0,        BUSY,  32'h0,        0,0,32'h0,32'h0,        1,0,32'h48, 32'h0,        0);
        tbl[15] = mk(0,0,32'h48, 0,0,32'h0,  32'h0,        ACCESS,32'hFFFFFFFF, 0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[16] = mk(0,0,32'h0,  1,0,32'h180,32'h0,        FREE,  32'h0,        0,1,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[17] = mk(0,0,32'h0,  1,0,32'h180,32'h0,        ACCESS,32'h0BADF00D, 0,0,32'h0,32'h0BADF00D, 1,0,32'h180,32'h0,        0);
        tbl[18] = mk(0,0,32'h0,  0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[19] = mk(0,0,32'h0,  1,0,32'h200,32'h0,        FREE,  32'h0,        0,1,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[20] = mk(0,0,32'h0,  1,0,32'h200,32'h0,        BUSY,  32'h0,        0,1,32'h0,32'h0,        1,0,32'h200,32'h0,        0);
        tbl[21] = mk(0,0,32'h0,  1,0,32'h200,32'h0,        ERROR, 32'h77777777, 0,0,32'h0,32'h0,        1,0,32'h200,32'h0,        0);
        tbl[22] = mk(0,0,32'h0,  0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        1);
        tbl[23] = mk(0,0,32'h0,  0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        1);
        tbl[24] = mk(0,0,32'h0,  0,1,32'h204,32'h13579BDF, FREE,  32'h0,        0,1,32'h0,32'h0,        0,0,32'h0,  32'h0,        1);
        tbl[25] = mk(0,0,32'h0,  0,1,32'h204,32'h13579BDF, BUSY,  32'h0,        0,1,32'h0,32'h0,        0,1,32'h204,32'h13579BDF, 1);
        tbl[26] = mk(1,0,32'h0,  0,1,32'h204,32'h13579BDF, BUSY,  32'h0,        0,1,32'h0,32'h0,        0,1,32'h204,32'h13579BDF, 1);
        tbl[27] = mk(0,0,32'h0,  0,0,32'h0,  32'h0,        ACCESS,32'h5555,     0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);
        tbl[28] = mk(0,0,32'h0,  0,0,32'h0,  32'h0,        FREE,  32'h0,        0,0,32'h0,32'h0,        0,0,32'h0,  32'h0,        0);

        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 29; i++) begin
            @(negedge CLK);
            RST = tbl[i].rst; iREN = tbl[i].iren; iaddr = tbl[i].ia;
            dREN = tbl[i].dren; dWEN = tbl[i].dwen; daddr = tbl[i].da; dstore = tbl[i].ds;
            ramstate = tbl[i].rs; ramload = tbl[i].rl;
            #1;
            chk($sformatf("v%0d_iwait", i),    32'(iwait),    32'(tbl[i].e_iwait));
            chk($sformatf("v%0d_dwait", i),    32'(dwait),    32'(tbl[i].e_dwait));
            chk($sformatf("v%0d_iload", i),    iload,         tbl[i].e_iload);
            chk($sformatf("v%0d_dload", i),    dload,         tbl[i].e_dload);
            chk($sformatf("v%0d_ramREN", i),   32'(ramREN),   32'(tbl[i].e_ren));
            chk($sformatf("v%0d_ramWEN", i),   32'(ramWEN),   32'(tbl[i].e_wen));
            chk($sformatf("v%0d_ramaddr", i),  ramaddr,       tbl[i].e_addr);
            chk($sformatf("v%0d_ramstore", i), ramstore,      tbl[i].e_store);
            chk($sformatf("v%0d_memerr", i),   32'(memerr),   32'(tbl[i].e_err));
        end

        // Data held continuously against a waiting fetch; RAM answers immediately.
        begin
            int cyc = 0;
            int dg = 0;
            int ig = 0;
            int first_i = -1;
            @(negedge CLK);
            RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
            @(negedge CLK);
            RST = 1'b0; iREN = 1'b1; iaddr = 32'h80;
            dREN = 1'b1; daddr = 32'h300; dstore = '0;
            ramstate = ACCESS; ramload = 32'h1234;
            while ((dg + ig) < 20 && cyc < 200) begin
                @(negedge CLK);
                #1;
                if (ramREN) begin
                    if (ramaddr == 32'h80) begin
                        if (first_i < 0) first_i = dg + ig;
                        ig++;
                    end else begin
                        dg++;
                    end
                end
                cyc++;
            end
            chk("grant_budget", 32'(cyc < 200), 32'd1);
`ifdef ARB_FAIRNESS_EN
            chk("fair_igrants", 32'(ig), 32'd4);
            chk("fair_first_igrant", 32'(first_i), 32'd4);
`else
            chk("strict_igrants", 32'(ig), 32'd0);
            chk("strict_dgrants", 32'(dg), 32'd20);
`endif
            @(negedge CLK);
            iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
